// File: rtl/alu_pipe_pkg.sv
// Purpose : shared opcode encoding and flag bit positions for the pipelined ALU.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_XOR    = 3'd2,
        ALU_RED    = 3'd3,
        ALU_SLL    = 3'd4,
        ALU_SRA    = 3'd5,
        ALU_ROR    = 3'd6,
        ALU_PADDSB = 3'd7
    } alu_op_t;

    // Bit positions inside the {Z, V, N} flag vector.
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/alu_pipe_core.sv
// Purpose : combinational ALU datapath producing result, shift-range error and raw Z/V/N.
// Latency : 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline decides when the result is captured.
// Ports   : i_a/i_b operands, i_op opcode -> o_res, o_err, o_z, o_v, o_n.
// Config  : ALU_PIPE_SAT_EN selects saturating ADD/SUB/PADDSB; otherwise they wrap.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_op_t          i_op,
    output logic [WIDTH-1:0] o_res,
    output logic             o_err,
    output logic             o_z,
    output logic             o_v,
    output logic             o_n
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int H       = WIDTH / 2;
    localparam int LANES   = WIDTH / LANE_W;

    logic [WIDTH-1:0]   w_add_raw, w_sub_raw, w_add_res, w_sub_res;
    logic               w_add_ovf, w_sub_ovf;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_shbad;
    logic [WIDTH-1:0]   w_sll, w_sra, w_ror, w_red, w_padd, w_res;
    logic               w_v, w_err;
    // Bits above H would be dropped by the [H:0] selection anyway, so the
    // reduction is accumulated directly in H+1 bits.
    logic [H:0]         w_red_sum;

    assign w_add_raw = i_a + i_b;
    assign w_sub_raw = i_a - i_b;
    assign w_add_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_add_raw[WIDTH-1] != i_a[WIDTH-1]);
    assign w_sub_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sub_raw[WIDTH-1] != i_a[WIDTH-1]);

`ifdef ALU_PIPE_SAT_EN
    // On overflow the true result has the sign of A, so saturate toward it.
    logic [WIDTH-1:0] w_sat_val;
    assign w_sat_val = {i_a[WIDTH-1], {(WIDTH-1){~i_a[WIDTH-1]}}};
    assign w_add_res = w_add_ovf ? w_sat_val : w_add_raw;
    assign w_sub_res = w_sub_ovf ? w_sat_val : w_sub_raw;
`else
    assign w_add_res = w_add_raw;
    assign w_sub_res = w_sub_raw;
`endif

    assign w_shamt = i_b[SHAMT_W-1:0];
    assign w_shbad = |i_b[WIDTH-1:SHAMT_W];
    assign w_sll   = i_a << w_shamt;
    assign w_sra   = $signed(i_a) >>> w_shamt;
    // A left shift by WIDTH yields zero, which covers the zero-amount case.
    assign w_ror   = (i_a >> w_shamt) | (i_a << (WIDTH - int'(w_shamt)));

    assign w_red_sum = {1'b0, i_a[H-1:0]} + {1'b0, i_a[WIDTH-1:H]}
                     + {1'b0, i_b[H-1:0]} + {1'b0, i_b[WIDTH-1:H]};
    assign w_red     = {{(WIDTH-H-1){w_red_sum[H]}}, w_red_sum};

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] w_la, w_lb, w_ls;
        assign w_la = i_a[g*LANE_W +: LANE_W];
        assign w_lb = i_b[g*LANE_W +: LANE_W];
        assign w_ls = w_la + w_lb;
`ifdef ALU_PIPE_SAT_EN
        logic w_lovf;
        assign w_lovf = (w_la[LANE_W-1] == w_lb[LANE_W-1]) && (w_ls[LANE_W-1] != w_la[LANE_W-1]);
        assign w_padd[g*LANE_W +: LANE_W] =
            w_lovf ? {w_la[LANE_W-1], {(LANE_W-1){~w_la[LANE_W-1]}}} : w_ls;
`else
        assign w_padd[g*LANE_W +: LANE_W] = w_ls;
`endif
    end

    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (i_op)
            ALU_ADD:    begin w_res = w_add_res; w_v = w_add_ovf; end
            ALU_SUB:    begin w_res = w_sub_res; w_v = w_sub_ovf; end
            ALU_XOR:    w_res = i_a ^ i_b;
            ALU_RED:    w_res = w_red;
            ALU_SLL:    begin w_res = w_sll; w_err = w_shbad; end
            ALU_SRA:    begin w_res = w_sra; w_err = w_shbad; end
            ALU_ROR:    begin w_res = w_ror; w_err = w_shbad; end
            ALU_PADDSB: w_res = w_padd;
            default:    w_res = '0;
        endcase
    end

    assign o_res = w_res;
    assign o_err = w_err;
    assign o_v   = w_v;
    assign o_z   = (w_res == '0);
    assign o_n   = w_res[WIDTH-1];

endmodule

// File: rtl/alu_pipe.sv
// Purpose : two-stage pipelined ALU with valid/ready on both sides and a {Z,V,N} flag register.
// Latency : 2 register stages from input handshake to out_valid; 1 op/cycle with out_ready high.
// Backpressure: stalled stages hold data; in_ready is combinational from out_ready.
// Ports   : in_valid/in_ready + ALU_In1/ALU_In2/Opcode in; out_valid/out_ready + ALU_Out/Error out; Flags.
// Config  : ALU_PIPE_SAT_EN (see alu_pipe_core) selects saturating arithmetic.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ALU_In1,
    input  logic [WIDTH-1:0] ALU_In2,
    input  logic [2:0]       Opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             Error,
    output logic [2:0]       Flags
);

    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_a, r_s1_b;
    alu_op_t          r_s1_op;

    logic             r_s2_vld;
    logic [WIDTH-1:0] r_s2_res;
    logic             r_s2_err;
    alu_op_t          r_s2_op;
    logic [2:0]       r_s2_flg;

    logic [2:0]       r_flags;

    logic             w_s1_adv, w_s2_adv, w_out_hs;
    logic [WIDTH-1:0] w_core_res;
    logic             w_core_err, w_core_z, w_core_v, w_core_n;

    assign w_s2_adv = ~r_s2_vld | out_ready;
    assign w_s1_adv = ~r_s1_vld | w_s2_adv;
    assign w_out_hs = r_s2_vld & out_ready;

    alu_pipe_core #(.WIDTH(WIDTH), .LANE_W(LANE_W)) u_core (
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .i_op  (r_s1_op),
        .o_res (w_core_res),
        .o_err (w_core_err),
        .o_z   (w_core_z),
        .o_v   (w_core_v),
        .o_n   (w_core_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_op  <= ALU_ADD;
            r_s2_vld <= 1'b0;
            r_s2_res <= '0;
            r_s2_err <= 1'b0;
            r_s2_op  <= ALU_ADD;
            r_s2_flg <= 3'b000;
            r_flags  <= 3'b000;
        end else begin
            if (w_s1_adv) begin
                r_s1_vld <= in_valid;
                if (in_valid) begin
                    r_s1_a  <= ALU_In1;
                    r_s1_b  <= ALU_In2;
                    r_s1_op <= alu_op_t'(Opcode);
                end
            end
            // Data only reloads on a real transfer so the output stays put across bubbles.
            if (w_s2_adv) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_res <= w_core_res;
                    r_s2_err <= w_core_err;
                    r_s2_op  <= r_s1_op;
                    r_s2_flg <= {w_core_z, w_core_v, w_core_n};
                end
            end
            // Flags commit only when a clean result is actually consumed.
            if (w_out_hs && !r_s2_err) begin
                case (r_s2_op)
                    ALU_ADD, ALU_SUB:                  r_flags <= r_s2_flg;
                    ALU_XOR, ALU_SLL, ALU_SRA, ALU_ROR: r_flags[FLAG_Z] <= r_s2_flg[FLAG_Z];
                    default:                           r_flags <= r_flags;
                endcase
            end
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_vld;
    assign ALU_Out   = r_s2_res;
    assign Error     = r_s2_err;
    assign Flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    import alu_pipe_pkg::*;

`ifdef ALU_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] ALU_In1 = '0;
    logic [15:0] ALU_In2 = '0;
    logic [2:0]  Opcode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] ALU_Out;
    logic        Error;
    logic [2:0]  Flags;

    typedef struct {
        logic [15:0] res;
        logic        err;
        logic [2:0]  flg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   flg_pend = 1'b0;
    logic [2:0] flg_exp;

    alu_pipe #(.WIDTH(16), .LANE_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALU_In1   (ALU_In1),
        .ALU_In2   (ALU_In2),
        .Opcode    (Opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_Out   (ALU_Out),
        .Error     (Error),
        .Flags     (Flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] eo_s, input logic [15:0] eo_w, input logic ee,
                            input logic [2:0] ef_s, input logic [2:0] ef_w);
        exp_t e;
        e.res = SAT ? eo_s : eo_w;
        e.err = ee;
        e.flg = SAT ? ef_s : ef_w;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the op was accepted.
    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eo_s, input logic [15:0] eo_w, input logic ee,
                        input logic [2:0] ef_s, input logic [2:0] ef_w, input bit track);
        bit done = 1'b0;
        if (track) push_exp(eo_s, eo_w, ee, ef_s, ef_w);
        Opcode = op; ALU_In1 = a; ALU_In2 = b; in_valid = 1'b1;
        for (int g = 0; g < 50 && !done; g++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk) #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int g = 0; g < 100 && exp_q.size() != 0; g++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard monitor: compares each consumed result, then Flags one cycle later.
    always @(negedge clk) begin
        if (rst) begin
            flg_pend = 1'b0;
        end else begin
            if (flg_pend) begin
                check("flags", Flags, flg_exp);
                flg_pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: got %0h expected no output", ALU_Out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("alu_out", ALU_Out, e.res);
                    check("error", Error, e.err);
                    flg_pend = 1'b1;
                    flg_exp  = e.flg;
                end
            end
        end
    end

    initial begin
        #2 rst = 1'b1;
        #5;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_out", ALU_Out, 0);
        check("rst_error", Error, 0);
        check("rst_flags", Flags, 0);
        @(posedge clk) #1 rst = 1'b0;
        @(posedge clk) #1;

        // Back-to-back directed vectors: (op, A, B, out sat, out wrap, err, flags sat, flags wrap)
        send(ALU_ADD,    16'h7000, 16'h1000, 16'h7FFF, 16'h8000, 1'b0, 3'b010, 3'b011, 1);
        send(ALU_SUB,    16'h80C2, 16'h7CFF, 16'h8000, 16'h03C3, 1'b0, 3'b011, 3'b010, 1);
        send(ALU_XOR,    16'h00FF, 16'h00FF, 16'h0000, 16'h0000, 1'b0, 3'b111, 3'b110, 1);
        send(ALU_RED,    16'h1234, 16'h5678, 16'hFF14, 16'hFF14, 1'b0, 3'b111, 3'b110, 1);
        send(ALU_PADDSB, 16'h7777, 16'h1111, 16'h7777, 16'h8888, 1'b0, 3'b111, 3'b110, 1);
        send(ALU_SRA,    16'h8000, 16'h000F, 16'hFFFF, 16'hFFFF, 1'b0, 3'b011, 3'b010, 1);
        send(ALU_ROR,    16'h0001, 16'h0001, 16'h8000, 16'h8000, 1'b0, 3'b011, 3'b010, 1);
        send(ALU_SLL,    16'h0001, 16'h0011, 16'h0002, 16'h0002, 1'b1, 3'b011, 3'b010, 1);
        send(ALU_ADD,    16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 3'b100, 3'b100, 1);
        send(ALU_ADD,    16'h8000, 16'h8000, 16'h8000, 16'h0000, 1'b0, 3'b011, 3'b110, 1);
        send(ALU_PADDSB, 16'h8888, 16'h8888, 16'h8888, 16'h0000, 1'b0, 3'b011, 3'b110, 1);
        send(ALU_SRA,    16'h8000, 16'h0104, 16'hF800, 16'hF800, 1'b1, 3'b011, 3'b110, 1);
        send(ALU_XOR,    16'h1234, 16'h00FF, 16'h12CB, 16'h12CB, 1'b0, 3'b011, 3'b010, 1);
        wait_drain();

        // Backpressure: two ops fill the pipe, the third is refused until out_ready rises.
        @(posedge clk) #1 out_ready = 1'b0;
        send(ALU_SUB, 16'h0005, 16'h0003, 16'h0002, 16'h0002, 1'b0, 3'b000, 3'b000, 1);
        send(ALU_XOR, 16'h000F, 16'h00F0, 16'h00FF, 16'h00FF, 1'b0, 3'b000, 3'b000, 1);
        push_exp(16'h8001, 16'h8001, 1'b0, 3'b000, 3'b000);
        Opcode = ALU_ROR; ALU_In1 = 16'h0003; ALU_In2 = 16'h0001; in_valid = 1'b1;
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_hold_out", ALU_Out, 16'h0002);
            check("stall_hold_err", Error, 0);
            @(negedge clk);
        end
        @(posedge clk) #1 out_ready = 1'b1;
        @(negedge clk);
        check("resume_in_ready", in_ready, 1);
        check("burst_0", out_valid, 1);
        @(posedge clk) #1 in_valid = 1'b0;
        @(negedge clk);
        check("burst_1", out_valid, 1);
        @(negedge clk);
        check("burst_2", out_valid, 1);
        wait_drain();

        // Reset with two ops in flight: they must vanish and never reappear.
        @(posedge clk) #1 out_ready = 1'b0;
        send(ALU_ADD, 16'h0001, 16'h0002, 16'h0003, 16'h0003, 1'b0, 3'b000, 3'b000, 0);
        send(ALU_SUB, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 3'b001, 3'b001, 0);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_flags", Flags, 0);
        check("mid_rst_alu_out", ALU_Out, 0);
        @(posedge clk) #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("no_stale_out", out_valid, 0);
        end
        check("post_rst_flags", Flags, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
